// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus bundle.
//   Instruction memory side : imem_addr (stage -> mem), imem_instr, imem_rdy (mem -> stage)
//   IF/ID decode side       : if_valid, if_pc, if_pc_plus4, if_instr (stage -> decode),
//                             if_ready (decode -> stage)
// master = fetch stage, slave = memory/decode side.
interface instr_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_rdy;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  imem_rdy,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_pc_plus4,
    output if_instr
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output imem_rdy,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_pc_plus4,
    input  if_instr
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, presents it combinationally to
// instruction memory and captures the returned word into the IF/ID register,
// handing it to decode over a valid/ready handshake. An EX-stage redirect
// flushes the in-flight instruction and reloads the PC.
//
// Ports:
//   clk, reset      clock / synchronous active-high reset
//   bus (master)    imem_addr/imem_instr/imem_rdy and IF/ID handshake signals
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     redirect target
//   fetch_oob       PC outside instruction memory, fetch halted
//   fetch_count     instructions delivered to decode (wraps)
//   if_misalign     misaligned redirect trap flag
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : misaligned redirect traps (PC kept, fetch stops until an
//               aligned redirect)
//   undefined : redirect target low two bits are forced to zero, flag tied 0
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  instr_fetch_stage_if.master         bus,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        fetch_oob,
  output logic [31:0]                 fetch_count,
  output logic                        if_misalign
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    OOB  = 2'd1,
    TRAP = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        valid_q, valid_n;
  logic [31:0] ipc_q, ipc_n;
  logic [31:0] ipc4_q, ipc4_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] count_q, count_n;
  logic        mis_q, mis_n;

  logic        oob;
  logic        accept;
  logic        fire;
  logic        mis_redirect;
  logic [31:0] aligned_target;

  // 33-bit compare so pc values near 2^32 do not wrap back into range.
  assign oob = ({1'b0, pc} + 33'd3) >= 33'(MEM_SIZE);

  assign accept = valid_q & bus.if_ready;
  assign fire   = (state == RUN) & ~oob & bus.imem_rdy & ~redirect_valid
                & (~valid_q | bus.if_ready);

  assign aligned_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign mis_redirect = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  assign mis_redirect = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = valid_q;
    ipc_n   = ipc_q;
    ipc4_n  = ipc4_q;
    instr_n = instr_q;
    count_n = count_q;
    mis_n   = mis_q;

    if (redirect_valid) begin
      // Flush: whatever decode sees this cycle is discarded and not counted.
      valid_n = 1'b0;
      if (mis_redirect) begin
        state_n = TRAP;
        mis_n   = 1'b1;
      end else begin
        state_n = RUN;
        pc_n    = aligned_target;
        mis_n   = 1'b0;
      end
    end else begin
      if (accept) begin
        count_n = count_q + 32'd1;
      end
      if (fire) begin
        ipc_n   = pc;
        ipc4_n  = pc + 32'd4;
        instr_n = bus.imem_instr;
        valid_n = 1'b1;
        pc_n    = pc + 32'd4;
      end else if (accept) begin
        valid_n = 1'b0;
      end
      if ((state == RUN) && oob) begin
        state_n = OOB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      valid_q <= 1'b0;
      ipc_q   <= '0;
      ipc4_q  <= 32'd4;
      instr_q <= NOP;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      valid_q <= valid_n;
      ipc_q   <= ipc_n;
      ipc4_q  <= ipc4_n;
      instr_q <= instr_n;
      count_q <= count_n;
      mis_q   <= mis_n;
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_valid    = valid_q;
  assign bus.if_pc       = ipc_q;
  assign bus.if_pc_plus4 = ipc4_q;
  assign bus.if_instr    = instr_q;
  assign fetch_oob       = (state == OOB) | oob;
  assign fetch_count     = count_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign if_misalign = mis_q;
`else
  assign if_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vectors, a transaction
// level reference model compared every cycle, and literal spot checks.
module tb_instr_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned MEM_SIZE = 256;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_oob;
  logic [31:0] fetch_count;
  logic        if_misalign;

  instr_fetch_stage_if bus ();

  instr_fetch_stage #(
    .RESET_PC (RESET_PC),
    .MEM_SIZE (MEM_SIZE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_oob      (fetch_oob),
    .fetch_count    (fetch_count),
    .if_misalign    (if_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: every word encodes its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  assign bus.imem_instr = mem_word(bus.imem_addr);

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what decode should see, tracked as a few plain facts.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] iinstr;
    logic [31:0] count;
    logic        valid;
    logic        halted;
    logic        trapped;
    logic        mis;
  } mstate_t;

  mstate_t m;

  function automatic bit outside(input logic [31:0] a);
    return (64'(a) + 64'd3) >= 64'(MEM_SIZE);
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input bit rst, input bit mem_rdy,
                                         input bit dec_rdy, input bit redir,
                                         input logic [31:0] rpc);
    mstate_t n;
    bit taken;
    n = s;
    if (rst) begin
      n.pc = RESET_PC; n.ipc = 32'd0; n.iinstr = 32'h0000_0013; n.count = 32'd0;
      n.valid = 1'b0; n.halted = 1'b0; n.trapped = 1'b0; n.mis = 1'b0;
      return n;
    end
    if (redir) begin
      n.valid = 1'b0;
      if (MISALIGN_TRAP && (rpc % 4 != 0)) begin
        n.trapped = 1'b1;
        n.mis     = 1'b1;
      end else begin
        n.pc      = rpc - (rpc % 4);
        n.halted  = 1'b0;
        n.trapped = 1'b0;
        n.mis     = 1'b0;
      end
      return n;
    end
    taken = s.valid && dec_rdy;
    if (taken) n.count = s.count + 1;
    if (!s.halted && !s.trapped && !outside(s.pc) && mem_rdy && (!s.valid || dec_rdy)) begin
      n.ipc    = s.pc;
      n.iinstr = mem_word(s.pc);
      n.valid  = 1'b1;
      n.pc     = s.pc + 4;
    end else if (taken) begin
      n.valid = 1'b0;
    end
    if (outside(s.pc) && !s.trapped) n.halted = 1'b1;
    return n;
  endfunction

  always @(posedge clk)
    m <= model_step(m, reset, bus.imem_rdy, bus.if_ready, redirect_valid, redirect_pc);

  always @(negedge clk) begin
    if (started) begin
      check("imem_addr",   bus.imem_addr,   m.pc);
      check("if_valid",    32'(bus.if_valid), 32'(m.valid));
      check("if_pc",       bus.if_pc,       m.ipc);
      check("if_pc_plus4", bus.if_pc_plus4, m.ipc + 32'd4);
      check("if_instr",    bus.if_instr,    m.iinstr);
      check("fetch_oob",   32'(fetch_oob),  32'(m.halted || outside(m.pc)));
      check("fetch_count", fetch_count,     m.count);
      check("if_misalign", 32'(if_misalign), 32'(m.mis));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // {if_ready, imem_rdy, redirect_valid, redirect_pc}
  logic [34:0] vec [14] = '{
    {3'b110, 32'h0000_0000}, {3'b010, 32'h0000_0000}, {3'b000, 32'h0000_0000},
    {3'b100, 32'h0000_0000}, {3'b111, 32'h0000_0080}, {3'b110, 32'h0000_0000},
    {3'b010, 32'h0000_0000}, {3'b111, 32'h0000_007E}, {3'b110, 32'h0000_0000},
    {3'b111, 32'h0000_00FC}, {3'b110, 32'h0000_0000}, {3'b110, 32'h0000_0000},
    {3'b111, 32'h0000_0008}, {3'b110, 32'h0000_0000}
  };

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    bus.if_ready = 1'b1;
    bus.imem_rdy = 1'b1;
    step(2);
    started = 1'b1;
    check("rst_addr",  bus.imem_addr, 32'h0);
    check("rst_valid", 32'(bus.if_valid), 32'h0);
    check("rst_plus4", bus.if_pc_plus4, 32'h4);
    check("rst_instr", bus.if_instr, 32'h0000_0013);
    check("rst_count", fetch_count, 32'h0);

    // Sequential fetch.
    reset = 1'b0;
    step(4);
    check("seq_addr",  bus.imem_addr, 32'd16);
    check("seq_pc",    bus.if_pc, 32'd12);
    check("seq_instr", bus.if_instr, 32'hC0DE_000C);
    check("seq_count3", fetch_count, 32'd3);
    step(1);
    check("seq_count4", fetch_count, 32'd4);

    // Decode stall holding if_pc=8.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);
    bus.if_ready = 1'b0;
    step(3);
    check("stall_pc",    bus.if_pc, 32'd8);
    check("stall_addr",  bus.imem_addr, 32'd12);
    check("stall_count", fetch_count, 32'd2);
    bus.if_ready = 1'b1;
    step(1);
    check("unstall_count", fetch_count, 32'd3);

    // Redirect flushes the valid instruction at if_pc=12.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(1);
    check("flush_valid", 32'(bus.if_valid), 32'h0);
    check("flush_addr",  bus.imem_addr, 32'h40);
    check("flush_count", fetch_count, 32'd3);
    redirect_valid = 1'b0;
    step(1);
    check("redir_pc",    bus.if_pc, 32'h40);
    check("redir_valid", 32'(bus.if_valid), 32'h1);

    // Run off the end of memory.
    redirect_valid = 1'b1; redirect_pc = 32'hF0;
    step(1);
    redirect_valid = 1'b0;
    step(4);
    check("last_pc",   bus.if_pc, 32'hFC);
    check("oob_flag",  32'(fetch_oob), 32'h1);
    step(1);
    check("oob_drain", 32'(bus.if_valid), 32'h0);
    check("oob_addr",  bus.imem_addr, 32'h100);
    step(2);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step(1);
    check("oob_exit", 32'(fetch_oob), 32'h0);
    redirect_valid = 1'b0;
    step(1);

    // Top of address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    check("wrap_oob", 32'(fetch_oob), 32'h1);
    step(1);
    check("wrap_nofetch", 32'(bus.if_valid), 32'h0);

    // Memory stall then reset mid-stall with a redirect pending.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step(1);
    redirect_valid = 1'b0;
    step(1);
    bus.imem_rdy = 1'b0;
    step(2);
    check("mstall_addr",  bus.imem_addr, 32'h14);
    check("mstall_valid", 32'(bus.if_valid), 32'h0);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step(1);
    check("mrst_addr",  bus.imem_addr, RESET_PC);
    check("mrst_count", fetch_count, 32'h0);
    reset = 1'b0; redirect_valid = 1'b0; bus.imem_rdy = 1'b1;

    // Misaligned redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    step(1);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_flag", 32'(if_misalign), 32'h1);
    check("mis_addr", bus.imem_addr, 32'h0);
    redirect_valid = 1'b0;
    step(1);
    check("mis_nofetch", 32'(bus.if_valid), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step(1);
    check("mis_clear", 32'(if_misalign), 32'h0);
`endif
    check("mis_addr20", bus.imem_addr, 32'h20);
    redirect_valid = 1'b0;
    step(1);
    check("mis_fetch", bus.if_pc, 32'h20);

    // Mixed directed vectors, checked by the model.
    for (int unsigned i = 0; i < 14; i++) begin
      bus.if_ready   = vec[i][34];
      bus.imem_rdy   = vec[i][33];
      redirect_valid = vec[i][32];
      redirect_pc    = vec[i][31:0];
      step(1);
    end
    redirect_valid = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
